// File: rtl/uart_core.sv
// rtl/uart_core.sv - 8N1 UART transmitter clocked by the baud clock.
// Optional even-parity bit between data and stop when UART_PARITY_EN is defined.
module uart_core #(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk_baud,
    input  logic       rst,
    input  logic [7:0] tx_byte,
    input  logic       start_send,
    output logic       tx,
    output logic       done,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          tx_q, tx_n;
    logic          done_q, done_n;
    logic          bit_end;
    logic [2:0]    idx_inc;

    always_ff @(posedge clk_baud or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            idx    <= '0;
            cnt    <= '0;
            tx_q   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            tx_q   <= tx_n;
            done_q <= done_n;
        end
    end

    // tx_n is the line level for the cycle after this edge, so tx stays a pure flop output.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
        cnt_n   = cnt;
        tx_n    = tx_q;
        done_n  = 1'b0;
        bit_end = (cnt == CNT_MAX);
        idx_inc = idx + 3'd1;
        case (state)
            IDLE: begin
                tx_n  = 1'b1;
                cnt_n = '0;
                idx_n = '0;
                if (start_send) begin
                    shreg_n = tx_byte;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = DATA;
                    tx_n    = shreg[0];
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx == LAST_IDX) begin
`ifdef UART_PARITY_EN
                        state_n = PARITY;
                        tx_n    = ^shreg;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        idx_n = idx_inc;
                        tx_n  = shreg[idx_inc];
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = STOP;
                    tx_n    = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign tx   = tx_q;
    assign done = done_q;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - self-checking bench for uart_core at CLKS_PER_BIT 1 and 4.
// Define UART_PARITY_EN for both RTL and bench to check the parity frame.
module tb_uart_core;

`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] b1, b4;
    logic       s1, s4;
    logic       tx1, d1, bz1, tx4, d4, bz4;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    uart_core #(.CLKS_PER_BIT(1)) dut1 (
        .clk_baud(clk), .rst(rst), .tx_byte(b1), .start_send(s1),
        .tx(tx1), .done(d1), .busy(bz1)
    );

    uart_core #(.CLKS_PER_BIT(4)) dut4 (
        .clk_baud(clk), .rst(rst), .tx_byte(b4), .start_send(s4),
        .tx(tx4), .done(d4), .busy(bz4)
    );

    typedef struct {
        logic [7:0] data;
        int         sel;
        logic       hold;
        logic       exp_par;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int sel, input logic [7:0] b, input logic s);
        if (sel == 0) begin b1 = b; s1 = s; end
        else begin b4 = b; s4 = s; end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel == 0) ? tx1 : tx4;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bz1 : bz4;
    endfunction
    function automatic logic get_done(input int sel);
        return (sel == 0) ? d1 : d4;
    endfunction

    // Reference: bit position p of a frame is start 0, data LSB first, optional parity, stop 1.
    function automatic logic frame_bit(input logic [7:0] data, input logic par, input int p);
        if (p == 0) return 1'b0;
        if (p <= 8) return data[p-1];
        if (p == 9 && NB == 11) return par;
        return 1'b1;
    endfunction

    function automatic logic even_par(input logic [7:0] data);
        int ones = 0;
        for (int k = 0; k < 8; k++) ones += (data >> k) & 1;
        return logic'(ones % 2);
    endfunction

    // One idle cycle, then raise the request for the next edge.
    task automatic send(input int sel, input logic [7:0] data);
        @(negedge clk);
        chk("idle_tx", get_tx(sel), 1);
        chk("idle_busy", get_busy(sel), 0);
        drive(sel, data, 1'b1);
    endtask

    // Checks a frame already accepted at the coming edge; garbage inputs mid-frame must be ignored.
    task automatic check_frame(input int sel, input logic [7:0] data, input logic par,
                               input logic [7:0] next_byte, input logic hold);
        int cpb = (sel == 0) ? 1 : 4;
        for (int c = 0; c < NB * cpb; c++) begin
            @(negedge clk);
            chk("frame_tx", get_tx(sel), frame_bit(data, par, c / cpb));
            chk("frame_busy", get_busy(sel), 1);
            chk("frame_done", get_done(sel), 0);
            drive(sel, 8'($urandom), hold ? 1'b1 : 1'($urandom));
        end
        @(negedge clk);
        chk("done_pulse", get_done(sel), 1);
        chk("done_tx", get_tx(sel), 1);
        chk("done_busy", get_busy(sel), 0);
        drive(sel, next_byte, hold);
    endtask

    vec_t vecs[7];
    logic pending;

    initial begin
        vecs[0] = '{8'h30, 0, 1'b1, 1'b0};
        vecs[1] = '{8'h30, 0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 0, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 0, 1'b0, 1'b1};
        vecs[4] = '{8'hA5, 1, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1, 1'b1, 1'b1};
        vecs[6] = '{8'h01, 1, 1'b0, 1'b1};

        rst = 1'b1; b1 = 8'h00; b4 = 8'h00; s1 = 1'b0; s4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx", tx1, 1);
        chk("rst_done", d1, 0);
        chk("rst_busy", bz1, 0);
        chk("rst_tx4", tx4, 1);
        rst = 1'b0;

        // Abort mid-frame: reach data bit 3 of 0x30 (a zero), then assert reset between edges.
        send(0, 8'h30);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(0, 8'h30, 1'b0);
        end
        chk("pre_rst_tx", tx1, 0);
        chk("pre_rst_busy", bz1, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_tx", tx1, 1);
        chk("async_rst_busy", bz1, 0);
        chk("async_rst_done", d1, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("post_rst_tx", tx1, 1);
            chk("post_rst_busy", bz1, 0);
            chk("post_rst_done", d1, 0);
        end

        pending = 1'b0;
        for (int i = 0; i < 7; i++) begin
            logic       h;
            logic [7:0] nb;
            h  = vecs[i].hold && (i + 1 < 7) && (vecs[i+1].sel == vecs[i].sel);
            nb = (i + 1 < 7) ? vecs[i+1].data : 8'h00;
            if (!pending) send(vecs[i].sel, vecs[i].data);
            check_frame(vecs[i].sel, vecs[i].data, vecs[i].exp_par, nb, h);
            pending = h;
        end

        pending = 1'b0;
        begin
            int         sel;
            logic [7:0] data, nb;
            logic       h;
            sel  = 0;
            data = 8'($urandom);
            for (int i = 0; i < 14; i++) begin
                if (!pending) begin
                    sel = int'($urandom_range(1, 0));
                    send(sel, data);
                end
                nb = 8'($urandom);
                h  = (i < 13) ? 1'($urandom) : 1'b0;
                check_frame(sel, data, even_par(data), nb, h);
                pending = h;
                data = nb;
            end
        end

        @(negedge clk);
        chk("final_idle1", tx1, 1);
        chk("final_idle4", tx4, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- 8-bit UART transmitter, 8N1 frame format.
- Serialises a parallel byte onto a single `tx` line when `start_send` is seen in idle.
- Pulses `done` when the frame is complete.
- Sits between byte-producing logic and the board TX pin; runs directly on the baud-rate clock by default.

Parameters:
- CLKS_PER_BIT, default 1: number of `clk_baud` cycles each serial bit is held. Legal range 1..65535. Default 1 means `clk_baud` is the bit clock.
- DATA_BITS, default 8: data bits per frame. Fixed at 8 for this release; other values are not supported.

Ports:
- clk_baud  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_byte  input  8  byte to transmit; sampled only when a frame is accepted.
- start_send  input  1  request to transmit; level-sensitive, may be held high permanently.
- tx  output  1  serial line, idle high.
- done  output  1  one-cycle pulse at end of each frame.
- busy  output  1  high while a frame (start, data or stop bit) is in progress.

Behaviour:
- Reset (async, rst=1): state=IDLE, tx=1, done=0, busy=0. Shift register and bit/clock counters are cleared. Any frame in progress is aborted immediately; tx goes high without waiting for a clock.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If start_send=1 at a rising edge: latch tx_byte into the shift register and go to START.
  - Otherwise stay in IDLE.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift-register bit[index], LSB first.
  - Each bit is held CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- done:
  - Registered; equals 1 for exactly the first cycle back in IDLE after STOP.
  - 0 in all other cycles, including after reset.
- busy: 1 in START, DATA and STOP.
- Latency: start bit appears on tx the cycle after start_send is sampled in IDLE.
- Frame length: 10*CLKS_PER_BIT cycles of tx activity.
- Back-to-back operation: with start_send held high, the IDLE cycle in which done=1 also accepts the next request. Frame period is 10*CLKS_PER_BIT + 1 cycles, with exactly one idle-high cycle between frames.
- tx_byte and start_send changes during START/DATA/STOP are ignored; the latched byte is used.
- start_send pulses shorter than one cycle, or arriving while busy, are not queued and are lost.
- Bit-period counter counts 0..CLKS_PER_BIT-1. Counter width is $clog2(CLKS_PER_BIT+1), minimum 1. Counter wraps to 0 at each bit boundary.
- tx is driven from a flop (glitch-free).

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the 8 data bits) is inserted as a PARITY state between DATA and STOP.
  - Parity bit is held CLKS_PER_BIT cycles.
  - Frame becomes 11*CLKS_PER_BIT cycles; back-to-back period 11*CLKS_PER_BIT + 1.
- Undefined: plain 8N1 as described above; no PARITY state exists.

Test Plan:
1. Reset: assert rst mid-frame (during DATA bit 3) -> tx=1, done=0, busy=0 immediately, before the next clock edge. After release with start_send=0, tx remains 1 indefinitely.
2. Single frame, CLKS_PER_BIT=1, tx_byte=0x30 ('0'), start_send pulsed 1 cycle -> tx sequence 0, 0,0,0,0,1,1,0,0, 1. done=1 exactly one cycle after the stop bit; busy high for 10 cycles.
3. Continuous start_send=1 with tx_byte=0x30 -> identical frames repeating every 11 cycles, done pulsing every 11 cycles, exactly one idle-high cycle between frames.
4. tx_byte changed from 0x30 to 0xFF during DATA -> current frame still sends 0x30; next frame sends 0xFF.
5. CLKS_PER_BIT=4, tx_byte=0xA5 -> each bit held 4 cycles. LSB-first pattern 1,0,1,0,0,1,0,1 between start 0 and stop 1. done pulses 41 cycles after the accepting edge.
6. UART_PARITY_EN defined, tx_byte=0x07 -> parity bit=1 after data bit 7, then stop bit. Back-to-back period 12 cycles at CLKS_PER_BIT=1.
